// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared constants for the decode-stage instruction queue: register address
// width, rs/rt field positions inside a MIPS-style instruction word, and the
// hard-wired zero register that never creates a dependency.
// -----------------------------------------------------------------------------
package id_pkg;

    localparam int REG_ADDR_W = 5;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : id_pkg

// File: rtl/id_inst_queue_if.sv
// -----------------------------------------------------------------------------
// id_inst_queue_if
// Bundles every non-clock/reset signal of id_inst_queue.
//   slave  : the queue itself (accepts IF pushes, presents head to decode,
//            receives branch flush and load-destination hazard sources)
//   master : the surrounding pipeline (IF, decode, EX/MEM hazard sources)
// Signals:
//   in_valid/in_pc/in_inst/in_ready        IF -> queue handshake
//   out_valid/out_pc/out_inst/out_ready    queue -> decode handshake
//   br_flush                               taken branch resolved in decode
//   haz_valid/haz_waddr                    in-flight load destinations
//   stallreq_for_id                        load-use stall request
//   count                                  occupancy (debug/perf)
// -----------------------------------------------------------------------------
interface id_inst_queue_if #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INST_W  = 32,
    parameter int NUM_HAZ = 2
);
    import id_pkg::*;

    logic                             in_valid;
    logic [PC_W-1:0]                  in_pc;
    logic [INST_W-1:0]                in_inst;
    logic                             in_ready;

    logic                             out_valid;
    logic [PC_W-1:0]                  out_pc;
    logic [INST_W-1:0]                out_inst;
    logic                             out_ready;

    logic                             br_flush;
    logic [NUM_HAZ-1:0]               haz_valid;
    logic [NUM_HAZ*REG_ADDR_W-1:0]    haz_waddr;
    logic                             stallreq_for_id;
    logic [$clog2(DEPTH+1)-1:0]       count;

    modport master (
        output in_valid, in_pc, in_inst, out_ready, br_flush, haz_valid, haz_waddr,
        input  in_ready, out_valid, out_pc, out_inst, stallreq_for_id, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, br_flush, haz_valid, haz_waddr,
        output in_ready, out_valid, out_pc, out_inst, stallreq_for_id, count
    );

endinterface : id_inst_queue_if

// File: rtl/id_hazard_cmp.sv
// -----------------------------------------------------------------------------
// id_hazard_cmp
// Compares one in-flight load destination against the rs/rt fields of the
// instruction at the queue head.
// Ports:
//   haz_valid  in  source holds an in-flight load
//   haz_waddr  in  destination register of that load
//   rs, rt     in  source registers of the head instruction
//   hit        out load-use dependency (never for register $0)
// -----------------------------------------------------------------------------
module id_hazard_cmp
    import id_pkg::*;
(
    input  logic                  haz_valid,
    input  logic [REG_ADDR_W-1:0] haz_waddr,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hit
);

    assign hit = haz_valid && (haz_waddr != ZERO_REG) &&
                 ((haz_waddr == rs) || (haz_waddr == rt));

endmodule : id_hazard_cmp

// File: rtl/id_inst_queue.sv
// -----------------------------------------------------------------------------
// id_inst_queue
// DEPTH-entry {pc, inst} FIFO between IF and decode with load-use hazard
// blocking of the head entry and branch flush that keeps the delay slot.
// Ports:
//   clk     in  clock
//   resetn  in  asynchronous active-low reset
//   q_if    slave modport of id_inst_queue_if (handshakes, flush, hazards)
// Optional build macro ID_QUEUE_BYPASS_EN: when the queue is empty an incoming
// instruction is presented to decode in the same cycle and, if accepted, never
// written to storage. Without it the head only comes from storage (>=1 cycle
// latency) and in_ready depends on registered occupancy alone.
// -----------------------------------------------------------------------------
module id_inst_queue
    import id_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INST_W  = 32,
    parameter int NUM_HAZ = 2
) (
    input logic            clk,
    input logic            resetn,
    id_inst_queue_if.slave q_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              slot_pending_q, slot_pending_d;

    logic [PC_W-1:0]   mem_pc_q   [DEPTH];
    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic              mem_we;

    logic              empty;
    logic              head_valid;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;
    logic [NUM_HAZ-1:0] haz_hit;
    logic              stall;
    logic              out_fire;
    logic              in_ready;
    logic              push;
    logic              push_store;
    logic              pop_store;
    logic [CNT_W-1:0]  remaining;

    assign empty = (count_q == '0);

    // Head selection. Storage contents are undefined while empty, so the
    // outputs are forced to zero rather than exposing stale data.
    // NOTE: every variable assigned in an always_comb gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        head_valid = !empty;
        head_pc    = empty ? '0 : mem_pc_q[rd_ptr_q];
        head_inst  = empty ? '0 : mem_inst_q[rd_ptr_q];
`ifdef ID_QUEUE_BYPASS_EN
        if (empty && q_if.in_valid) begin
            head_valid = 1'b1;
            head_pc    = q_if.in_pc;
            head_inst  = q_if.in_inst;
        end
`endif
    end

    for (genvar i = 0; i < NUM_HAZ; i++) begin : g_haz
        id_hazard_cmp u_cmp (
            .haz_valid (q_if.haz_valid[i]),
            .haz_waddr (q_if.haz_waddr[i*REG_ADDR_W +: REG_ADDR_W]),
            .rs        (head_inst[RS_MSB:RS_LSB]),
            .rt        (head_inst[RT_MSB:RT_LSB]),
            .hit       (haz_hit[i])
        );
    end

    assign stall     = head_valid && (|haz_hit);
    assign out_fire  = head_valid && q_if.out_ready && !stall;
    assign pop_store = out_fire && !empty;

`ifdef ID_QUEUE_BYPASS_EN
    // At full the head comes from storage, so out_fire has no path from the
    // input side here and this cannot form a combinational loop.
    assign in_ready   = (count_q != FULL_CNT) || out_fire;
    assign push       = q_if.in_valid && in_ready;
    // An instruction consumed straight from the input never enters storage.
    assign push_store = push && !(empty && out_fire);
`else
    assign in_ready   = (count_q != FULL_CNT);
    assign push       = q_if.in_valid && in_ready;
    assign push_store = push;
`endif

    always_comb begin
        rd_ptr_d       = rd_ptr_q + PTR_W'(pop_store);
        remaining      = count_q - CNT_W'(pop_store);
        wr_ptr_d       = wr_ptr_q;
        count_d        = remaining;
        slot_pending_d = slot_pending_q;
        mem_we         = 1'b0;

        // The first accepted push after an empty flush is the delay slot.
        if (push && slot_pending_q) begin
            slot_pending_d = 1'b0;
        end

        if (q_if.br_flush && !slot_pending_q) begin
            if (remaining != '0) begin
                // Keep only the oldest surviving entry; a same-cycle push is
                // younger and is dropped with the rest.
                count_d  = CNT_W'(1);
                wr_ptr_d = rd_ptr_d + PTR_W'(1);
            end else if (push_store) begin
                mem_we   = 1'b1;
                count_d  = CNT_W'(1);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                slot_pending_d = 1'b1;
            end
        end else if (push_store) begin
            mem_we   = 1'b1;
            count_d  = remaining + CNT_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            slot_pending_q <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            slot_pending_q <= slot_pending_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count/pointers
    // define which entries are live, and resetting RAM costs routing.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_pc_q[wr_ptr_q]   <= q_if.in_pc;
            mem_inst_q[wr_ptr_q] <= q_if.in_inst;
        end
    end

    assign q_if.in_ready        = in_ready;
    assign q_if.out_valid       = head_valid && !stall;
    assign q_if.out_pc          = head_pc;
    assign q_if.out_inst        = head_inst;
    assign q_if.stallreq_for_id = stall;
    assign q_if.count           = count_q;

endmodule : id_inst_queue
